// File: rtl/image_rotate_flip.sv
// Streams a greyscale image from a word-wide BRAM in rotated / flipped output raster order.
// Reads are credit-limited so a small return FIFO can absorb any downstream stall.
module image_rotate_flip #(
    parameter int          IMG_W        = 28,
    parameter int          IMG_H        = 28,
    parameter int          PIXEL_W      = 8,
    parameter int          BRAM_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR    = 32'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode_rot,
    input  logic               mode_flip,
    output logic               busy,
    output logic               image_done,
    output logic [PIXEL_W-1:0] pixel_o,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic [31:0]        bram_address,
    input  logic [31:0]        bram_data
);
    localparam int FIFO_DEPTH = BRAM_LATENCY + 2;
    localparam int MAX_DIM    = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW         = $clog2(MAX_DIM + 1);
    localparam int IDX_W      = $clog2(IMG_W * IMG_H);
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

    // Handshake: a pixel transfers when pixel_valid && pixel_ready at a rising clk edge;
    // until then pixel_valid stays high and pixel_o holds its value.

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]         rot_q;
    logic               flip_q;
    logic [CW-1:0]      ox, oy, ow, oh, fx, sx, sy;
    logic [IDX_W-1:0]   idx;
    logic               issue, last_pix, push, pop;
    logic [CNT_W-1:0]   outstanding, fifo_count;
    logic [CNT_W:0]     credit_used;
    logic               tag_valid [BRAM_LATENCY];
    logic [1:0]         tag_lane  [BRAM_LATENCY];
    logic [PIXEL_W-1:0] fifo_mem  [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [PIXEL_W-1:0] push_data;

    // Output coordinate -> source coordinate -> linear pixel index
    always_comb begin
        ow = rot_q[0] ? CW'(IMG_H) : CW'(IMG_W);
        oh = rot_q[0] ? CW'(IMG_W) : CW'(IMG_H);
        fx = flip_q ? (ow - CW'(1) - ox) : ox;
        sx = fx;
        sy = oy;
        case (rot_q)
            2'd1: begin sx = oy;                  sy = CW'(IMG_H - 1) - fx; end
            2'd2: begin sx = CW'(IMG_W - 1) - fx; sy = CW'(IMG_H - 1) - oy; end
            2'd3: begin sx = CW'(IMG_W - 1) - oy; sy = fx;                  end
            default: ;
        endcase
        idx = IDX_W'(sy) * IDX_W'(IMG_W) + IDX_W'(sx);
    end

    // Pending reads count against FIFO space so a late return always has a slot
    assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign issue        = (state == RUN) && (credit_used < CREDITS);
    assign last_pix     = (ox == ow - CW'(1)) && (oy == oh - CW'(1));
    assign bram_address = (state == RUN)
                        ? BASE_ADDR + {{(32 - IDX_W){1'b0}}, idx[IDX_W-1:2], 2'b00}
                        : BASE_ADDR;

    assign push        = tag_valid[BRAM_LATENCY-1];
    assign push_data   = PIXEL_W'(bram_data >> {tag_lane[BRAM_LATENCY-1], 3'b000});
    assign pixel_valid = (fifo_count != '0);
    assign pixel_o     = pixel_valid ? fifo_mem[rd_ptr] : '0;
    assign pop         = pixel_valid && pixel_ready;

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        image_done = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (issue && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // leave on the edge that hands over the final pixel
                if (outstanding == '0 &&
                    (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
                    state_nxt = DONE;
            end
            DONE: begin
                image_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rot_q       <= '0;
            flip_q      <= 1'b0;
            ox          <= '0;
            oy          <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
                tag_lane[i]  <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                rot_q  <= mode_rot;
                flip_q <= mode_flip;
                ox     <= '0;
                oy     <= '0;
            end else if (issue) begin
                if (ox == ow - CW'(1)) begin
                    ox <= '0;
                    oy <= oy + CW'(1);
                end else begin
                    ox <= ox + CW'(1);
                end
            end
            tag_valid[0] <= issue;
            tag_lane[0]  <= idx[1:0];
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_lane[i]  <= tag_lane[i-1];
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(push);
            fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_image_rotate_flip.sv
// Directed bench for image_rotate_flip on a 4x3 image whose byte i holds value i.
// Hand-computed output orders for all rotate/flip modes, stalls, restarts and aborts.
module tb_image_rotate_flip;
    localparam int          IMG_W = 4;
    localparam int          IMG_H = 3;
    localparam int          NPIX  = IMG_W * IMG_H;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    // Expected output order, row index = rot + 4*flip
    localparam logic [7:0] EXP [8][12] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11},
        '{ 8,  4,  0,  9,  5,  1, 10,  6,  2, 11,  7,  3},
        '{11, 10,  9,  8,  7,  6,  5,  4,  3,  2,  1,  0},
        '{ 3,  7, 11,  2,  6, 10,  1,  5,  9,  0,  4,  8},
        '{ 3,  2,  1,  0,  7,  6,  5,  4, 11, 10,  9,  8},
        '{ 0,  4,  8,  1,  5,  9,  2,  6, 10,  3,  7, 11},
        '{ 8,  9, 10, 11,  4,  5,  6,  7,  0,  1,  2,  3},
        '{11,  7,  3, 10,  6,  2,  9,  5,  1,  8,  4,  0}
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode_rot = 2'd0;
    logic        mode_flip = 1'b0;
    logic        busy, image_done, pixel_valid;
    logic        pixel_ready = 1'b1;
    logic [7:0]  pixel_o;
    logic [31:0] bram_address, bram_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int done_count = 0;
    int hs_in_image = 0;
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_pix;
    logic [7:0] exp_pix;
    logic [7:0] exp_q[$];
    logic [31:0] addr_pipe [LAT];

    image_rotate_flip #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIXEL_W(8), .BRAM_LATENCY(LAT), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode_rot(mode_rot), .mode_flip(mode_flip),
        .busy(busy), .image_done(image_done), .pixel_o(pixel_o), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .bram_address(bram_address), .bram_data(bram_data)
    );

    // clock / reset
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    // BRAM model: byte at offset i from BASE holds i, data appears LAT cycles after address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = 8'(a - BASE);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always @(posedge clk) begin
        addr_pipe[0] <= bram_address;
        for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
    assign bram_data = word_at(addr_pipe[LAT-1]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // downstream ready driver
    initial forever begin
        @(posedge clk);
        #1;
        pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // scoreboard / monitor, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (prev_stall) begin
                check("hold_valid", pixel_valid, 1);
                check("hold_pixel", pixel_o, prev_pix);
            end
            if (pixel_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (busy) check("fifo_occupancy_ok", dut.fifo_count <= LAT + 2, 1);
            if (pixel_valid && pixel_ready) begin
                check("pixel_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_pix = exp_q.pop_front();
                    check("pixel", pixel_o, exp_pix);
                end
                hs_in_image++;
                last_hs_cyc = cyc;
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_pix   = pixel_o;
            if (image_done) begin
                done_count++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // driver tasks
    task automatic kick(input int rot, input int flip);
        for (int i = 0; i < NPIX; i++) exp_q.push_back(EXP[rot + 4 * flip][i]);
        @(posedge clk);
        #1;
        start           = 1'b1;
        mode_rot        = 2'(rot);
        mode_flip       = 1'(flip);
        start_cyc       = cyc;
        first_valid_cyc = -1;
        hs_in_image     = 0;
        @(posedge clk);
        #1;
        start     = 1'b0;
        mode_rot  = ~mode_rot;
        mode_flip = ~mode_flip;
    endtask

    task automatic finish_image(input int base_done);
        int budget;
        budget = 0;
        while (done_count == base_done && budget < 400) begin
            @(negedge clk);
            #2;
            budget++;
        end
        check("image_done_count", done_count - base_done, 1);
        check("pixel_count", hs_in_image, NPIX);
        check("expected_left", exp_q.size(), 0);
        check("first_valid_latency", first_valid_cyc - start_cyc, LAT + 2);
        check("done_after_last_pixel", done_cyc - last_hs_cyc, 1);
        check("busy_at_done", busy, 0);
        exp_q.delete();
    endtask

    task automatic run_image(input int rot, input int flip, input bit probe);
        int base_done;
        base_done = done_count;
        kick(rot, flip);
        @(negedge clk);
        #2;
        check("busy_after_start", busy, 1);
        if (probe) begin
            @(posedge clk);
            #1;
            start     = 1'b1;
            mode_rot  = 2'(rot + 2);
            mode_flip = ~1'(flip);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        finish_image(base_done);
    endtask

    initial begin
        int base_done;
        int budget;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", image_done, 0);
        check("rst_valid", pixel_valid, 0);
        check("rst_pixel", pixel_o, 0);
        check("rst_address", bram_address, BASE);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // every rotation and flip, ready high, back to back
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 4; r++)
                run_image(r, f, 1'b0);

        // random backpressure
        rand_ready = 1'b1;
        run_image(0, 0, 1'b0);
        run_image(1, 1, 1'b0);
        run_image(2, 0, 1'b0);
        rand_ready = 1'b0;

        // start pulse while busy must not disturb the running image
        run_image(0, 0, 1'b1);

        // abort mid-image after five pixels
        base_done = done_count;
        kick(0, 0);
        budget = 0;
        while (hs_in_image < 5 && budget < 200) begin
            @(negedge clk);
            #2;
            budget++;
        end
        check("abort_pixels_reached", hs_in_image >= 5, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("abort_valid", pixel_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("abort_no_done", done_count - base_done, 0);
        check("abort_idle_valid", pixel_valid, 0);
        run_image(3, 0, 1'b0);

        repeat (10) @(negedge clk);
        check("final_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
